flexible_upsampling: RTL and testbench
======================================

FLEXIBLE_UPSAMPLING -- requirements
Module: flexible_upsampling

Interface
REQ-001 SHALL have parameter CIN, default 64, number of channels.
REQ-002 SHALL have parameter HSRC, default 19, source height/width.
REQ-003 SHALL have parameter HDST, default 27, upsampled height/width.
REQ-004 SHALL have parameter SCALE_Q88, default 180, source-per-destination step in Q8.8, i.e. round(256*HSRC/HDST).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port start  input  1  begin a frame; sampled only in IDLE.
REQ-008 SHALL have port in_valid  input  1  source pixel valid.
REQ-009 SHALL have port in_ready  output  1  block accepts source pixel.
REQ-010 SHALL have port in_data  input  8  source pixel, channel-serial, raster order within channel.
REQ-011 SHALL have port out_valid  output  1  upsampled pixel valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts pixel.
REQ-013 SHALL have port out_data  output  8  upsampled pixel, channel-serial, raster order.
REQ-014 SHALL have port out_last  output  1  high with last pixel (row HDST-1, col HDST-1) of each channel.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the final channel completes.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, EMIT, DONE.
REQ-017 IDLE -> LOAD when start=1; channel counter cleared; start ignored in all other states.
REQ-018 LOAD: in_ready=1; each in_valid&in_ready beat writes in_data to buffer[r][c], raster counters advance, c wraps at HSRC-1 and increments r.
REQ-019 LOAD -> EMIT on acceptance of pixel (HSRC-1, HSRC-1); destination counters cleared to (0,0).
REQ-020 EMIT: out_valid=1, out_data = buffer[sr][sc], sr=min((dr*SCALE_Q88)>>8, HSRC-1), sc likewise from dc.
REQ-021 Index product SHALL be computed at full width ($clog2(HDST)+16 bits) with no truncation before the shift.
REQ-022 out_data, out_valid, out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Destination counters advance only on out_valid&out_ready; dc wraps at HDST-1 and increments dr.
REQ-024 On acceptance of pixel (HDST-1, HDST-1): if channel = CIN-1 -> DONE, else channel+1 and -> LOAD with source counters cleared.
REQ-025 DONE lasts exactly one cycle with done=1, then -> IDLE.
REQ-026 in_ready=0 in IDLE, EMIT, DONE; out_valid=0 in IDLE, LOAD, DONE; no overlap of load and emit.
REQ-027 Latency: first out_valid of a channel one cycle after the last source pixel of that channel is accepted.
REQ-028 Buffer holds one channel (HSRC*HSRC*8 bits); contents not cleared between channels, fully overwritten by each LOAD.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, all counters 0, in_ready=0, out_valid=0, out_last=0, done=0, out_data=0; buffer contents need not reset.
REQ-030 Reset asserted mid-LOAD or mid-EMIT SHALL abandon the frame; after release block waits in IDLE for a new start.

Verification
REQ-031 Defaults, start, channel 0 source pixel (r,c)=r*19+c mod 256, out_ready=1 -> out (0,0)=0, (0,2)=1, (2,0)=19, (26,26)=18*19+18 mod 256=104, out_last on 729th beat.
REQ-032 Full CIN=64 frame with out_ready=1 -> 64*729 out beats, 64 out_last pulses, single done pulse one cycle after final beat, then IDLE.
REQ-033 out_ready toggled randomly, in_valid gapped -> output sequence identical to REQ-031, data stable during stalls, no beat lost or duplicated.
REQ-034 start pulsed during LOAD and EMIT -> no effect; in_valid during EMIT -> in_ready=0, no buffer write.
REQ-035 rst_n low mid-EMIT of channel 5 -> all outputs 0 next evaluation, IDLE; new start restarts at channel 0.
REQ-036 HSRC=2, HDST=3, SCALE_Q88=171 -> dst indices 0,1,2 map to src 0,0,1; clamp never exceeds HSRC-1.

Source files
------------

// File: rtl/flexible_upsampling.sv
// ---------------------------------------------------------------------------
// flexible_upsampling
//
// Nearest-neighbour spatial upsampler for a channel-serial feature map.
// For each of CIN channels the block first loads one HSRC x HSRC source plane
// into an internal buffer, then emits the HDST x HDST destination plane.
// Destination index d maps to source index min((d * SCALE_Q88) >> 8, HSRC-1),
// independently for rows and columns. Loading and emitting never overlap.
//
// Ports
//   clk        : single clock, all logic on the rising edge
//   rst_n      : asynchronous active-low reset, abandons any frame in flight
//   start      : begins a frame of CIN channels; only looked at in IDLE
//   in_valid   : source pixel valid
//   in_ready   : block accepts a source pixel (high only while loading)
//   in_data    : source pixel, raster order within a channel
//   out_valid  : destination pixel valid (high only while emitting)
//   out_ready  : downstream accepts the destination pixel
//   out_data   : destination pixel, raster order within a channel
//   out_last   : marks pixel (HDST-1, HDST-1) of every channel
//   done       : one-cycle pulse after the last channel has been emitted
// ---------------------------------------------------------------------------
module flexible_upsampling #(
    parameter int CIN       = 64,
    parameter int HSRC      = 19,
    parameter int HDST      = 27,
    parameter int SCALE_Q88 = 180
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       done
);

    // -----------------------------------------------------------------------
    // Widths
    // -----------------------------------------------------------------------
    localparam int CH_W   = (CIN > 1) ? $clog2(CIN) : 1;
    localparam int SRC_W  = (HSRC > 1) ? $clog2(HSRC) : 1;
    localparam int DST_W  = (HDST > 1) ? $clog2(HDST) : 1;
    localparam int DEPTH  = HSRC * HSRC;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Index product is kept at full width so no bits are lost before the
    // Q8.8 shift.
    localparam int PROD_W = $clog2(HDST) + 16;

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CIN - 1);
    localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(HSRC - 1);
    localparam logic [DST_W-1:0] DST_LAST = DST_W'(HDST - 1);

    // -----------------------------------------------------------------------
    // FSM encoding
    // -----------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]        state_q,   state_d;
    logic [CH_W-1:0]   chan_q,    chan_d;
    logic [SRC_W-1:0]  src_r_q,   src_r_d;
    logic [SRC_W-1:0]  src_c_q,   src_c_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DST_W-1:0]  dst_r_q,   dst_r_d;
    logic [DST_W-1:0]  dst_c_q,   dst_c_d;

    // One channel plane of source pixels.
    logic [7:0] buf_mem [DEPTH];

    logic              in_fire;
    logic              out_fire;
    logic              src_last_col;
    logic              src_last_row;
    logic              dst_last_col;
    logic              dst_last_row;
    logic [SRC_W-1:0]  map_r;
    logic [SRC_W-1:0]  map_c;
    logic [ADDR_W-1:0] rd_addr;

    // -----------------------------------------------------------------------
    // Destination -> source index mapping with clamp to the last source index
    // -----------------------------------------------------------------------
    function automatic logic [SRC_W-1:0] map_idx(input logic [DST_W-1:0] d);
        logic [PROD_W-1:0] prod;
        logic [PROD_W-1:0] shifted;
        prod    = PROD_W'(d) * PROD_W'(SCALE_Q88);
        shifted = prod >> 8;
        if (shifted > PROD_W'(HSRC - 1)) begin
            return SRC_LAST;
        end
        return SRC_W'(shifted);
    endfunction

    assign map_r   = map_idx(dst_r_q);
    assign map_c   = map_idx(dst_c_q);
    assign rd_addr = ADDR_W'(map_r) * ADDR_W'(HSRC) + ADDR_W'(map_c);

    // -----------------------------------------------------------------------
    // Handshakes and outputs (all decoded from registered state, so they are
    // naturally stable while a beat is stalled)
    // -----------------------------------------------------------------------
    assign in_ready     = (state_q == ST_LOAD);
    assign out_valid    = (state_q == ST_EMIT);
    assign done         = (state_q == ST_DONE);
    assign in_fire      = in_valid && in_ready;
    assign out_fire     = out_valid && out_ready;
    assign src_last_col = (src_c_q == SRC_LAST);
    assign src_last_row = (src_r_q == SRC_LAST);
    assign dst_last_col = (dst_c_q == DST_LAST);
    assign dst_last_row = (dst_r_q == DST_LAST);
    assign out_last     = out_valid && dst_last_row && dst_last_col;
    assign out_data     = out_valid ? buf_mem[rd_addr] : 8'd0;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one
        // unassigned; that is what keeps this block free of inferred latches.
        state_d   = state_q;
        chan_d    = chan_q;
        src_r_d   = src_r_q;
        src_c_d   = src_c_q;
        wr_addr_d = wr_addr_q;
        dst_r_d   = dst_r_q;
        dst_c_d   = dst_c_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    chan_d    = '0;
                    src_r_d   = '0;
                    src_c_d   = '0;
                    wr_addr_d = '0;
                end
            end

            ST_LOAD: begin
                if (in_fire) begin
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (src_last_col) begin
                        src_c_d = '0;
                        if (src_last_row) begin
                            // Whole plane is in; emission starts next cycle.
                            state_d   = ST_EMIT;
                            src_r_d   = '0;
                            wr_addr_d = '0;
                            dst_r_d   = '0;
                            dst_c_d   = '0;
                        end else begin
                            src_r_d = src_r_q + 1'b1;
                        end
                    end else begin
                        src_c_d = src_c_q + 1'b1;
                    end
                end
            end

            ST_EMIT: begin
                if (out_fire) begin
                    if (dst_last_col) begin
                        dst_c_d = '0;
                        if (dst_last_row) begin
                            dst_r_d = '0;
                            if (chan_q == CH_LAST) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d   = ST_LOAD;
                                chan_d    = chan_q + 1'b1;
                                src_r_d   = '0;
                                src_c_d   = '0;
                                wr_addr_d = '0;
                            end
                        end else begin
                            dst_r_d = dst_r_q + 1'b1;
                        end
                    end else begin
                        dst_c_d = dst_c_q + 1'b1;
                    end
                end
            end

            default: begin  // ST_DONE
                state_d = ST_IDLE;
                chan_d  = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples the values from
        // before this edge, independent of statement order.
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            chan_q    <= '0;
            src_r_q   <= '0;
            src_c_q   <= '0;
            wr_addr_q <= '0;
            dst_r_q   <= '0;
            dst_c_q   <= '0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            src_r_q   <= src_r_d;
            src_c_q   <= src_c_d;
            wr_addr_q <= wr_addr_d;
            dst_r_q   <= dst_r_d;
            dst_c_q   <= dst_c_d;
        end
    end

    // -----------------------------------------------------------------------
    // Plane buffer
    // -----------------------------------------------------------------------
    // NOTE: the buffer has no reset; every entry is rewritten by each LOAD
    // before it can be read, and leaving it out lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            buf_mem[wr_addr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_flexible_upsampling.sv
// ---------------------------------------------------------------------------
// tb_flexible_upsampling
//
// Directed bench for flexible_upsampling. A small instance (2x2 -> 3x3, two
// channels) is checked against a hand-written vector table; the default
// instance (19x19 -> 27x27, 64 channels) is checked with hand-computed spot
// points plus a nearest-neighbour reference, including stalls, gapped input,
// stray start/in_valid, a mid-frame reset and one full 64-channel frame.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_flexible_upsampling;

    logic clk;
    logic rst_n;

    // default instance
    logic       start, in_valid, in_ready, out_valid, out_ready, out_last, done;
    logic [7:0] in_data, out_data;

    // small instance
    logic       s_start, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic       s_out_last, s_done;
    logic [7:0] s_in_data, s_out_data;

    int total = 0;
    int bad   = 0;

    flexible_upsampling dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done)
    );

    flexible_upsampling #(
        .CIN       (2),
        .HSRC      (2),
        .HDST      (3),
        .SCALE_Q88 (171)
    ) dut_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s_start),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .out_last  (s_out_last),
        .done      (s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Checking helpers and reference
    // -----------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Source pattern: channel 0 is (r*19+c) mod 256, other channels offset.
    function automatic logic [7:0] src_pix(input int ch, input int r, input int c);
        return 8'((r * 19 + c + ch * 37) & 255);
    endfunction

    function automatic int near_idx(input int d);
        int s;
        s = (d * 180) / 256;
        if (s > 18) s = 18;
        return s;
    endfunction

    function automatic logic [7:0] exp_pix(input int ch, input int beat);
        return src_pix(ch, near_idx(beat / 27), near_idx(beat % 27));
    endfunction

    // Hand-computed channel-0 points of the default instance.
    typedef struct {
        int         beat;
        logic [7:0] data;
        logic       last;
    } spot_t;
    spot_t spots[9];

    // Hand-computed 3x3 output of the small instance for source {10,20,30,40}.
    typedef struct {
        logic [7:0] data;
        logic       last;
    } svec_t;
    svec_t svec[9];

    // -----------------------------------------------------------------------
    // Default-instance channel tasks; both start and end on a falling edge.
    // -----------------------------------------------------------------------
    task automatic load_channel(input int ch, input bit gapped, input bit poke);
        int cnt    = 0;
        int cyc    = 0;
        int ld_err = 0;
        while (cnt < 361 && cyc < 5000) begin
            cyc++;
            start    = poke && (cyc % 50 == 7);
            in_valid = gapped ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = src_pix(ch, cnt / 19, cnt % 19);
            if (in_ready !== 1'b1 || out_valid !== 1'b0) ld_err++;
            if (in_valid && in_ready) cnt++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check($sformatf("ch%0d load beats", ch), cnt, 361);
        check($sformatf("ch%0d load handshake", ch), ld_err, 0);
        check($sformatf("ch%0d first out_valid", ch), out_valid, 1);
    endtask

    task automatic emit_channel(input int ch, input bit stall, input bit poke, input bit spot);
        int beats = 0;
        int cyc   = 0;
        int derr  = 0;
        int lerr  = 0;
        int herr  = 0;
        while (beats < 729 && cyc < 5000) begin
            cyc++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) herr++;
            if (out_valid === 1'b1) begin
                if (out_data !== exp_pix(ch, beats)) derr++;
                if (out_last !== (beats == 728)) lerr++;
            end
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke) begin
                in_valid = 1'b1;
                in_data  = 8'hFF;
                start    = (cyc % 40 == 3);
            end
            if (spot && out_valid && out_ready) begin
                for (int i = 0; i < 9; i++) begin
                    if (spots[i].beat == beats) begin
                        check($sformatf("ch0 spot beat %0d data", beats), out_data, spots[i].data);
                        check($sformatf("ch0 spot beat %0d last", beats), out_last, spots[i].last);
                    end
                end
            end
            if (out_valid && out_ready) beats++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        check($sformatf("ch%0d emit beats", ch), beats, 729);
        check($sformatf("ch%0d emit data errors", ch), derr, 0);
        check($sformatf("ch%0d out_last errors", ch), lerr, 0);
        check($sformatf("ch%0d emit handshake errors", ch), herr, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    // Main sequence
    // -----------------------------------------------------------------------
    initial begin
        spots[0] = '{beat: 0,   data: 8'd0,   last: 1'b0};
        spots[1] = '{beat: 2,   data: 8'd1,   last: 1'b0};
        spots[2] = '{beat: 54,  data: 8'd19,  last: 1'b0};
        spots[3] = '{beat: 28,  data: 8'd0,   last: 1'b0};
        spots[4] = '{beat: 26,  data: 8'd18,  last: 1'b0};
        spots[5] = '{beat: 85,  data: 8'd40,  last: 1'b0};
        spots[6] = '{beat: 364, data: 8'd180, last: 1'b0};
        spots[7] = '{beat: 702, data: 8'd86,  last: 1'b0};
        spots[8] = '{beat: 728, data: 8'd104, last: 1'b1};

        svec[0] = '{data: 8'd10, last: 1'b0};
        svec[1] = '{data: 8'd10, last: 1'b0};
        svec[2] = '{data: 8'd20, last: 1'b0};
        svec[3] = '{data: 8'd10, last: 1'b0};
        svec[4] = '{data: 8'd10, last: 1'b0};
        svec[5] = '{data: 8'd20, last: 1'b0};
        svec[6] = '{data: 8'd30, last: 1'b0};
        svec[7] = '{data: 8'd30, last: 1'b0};
        svec[8] = '{data: 8'd40, last: 1'b1};

        start = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
        s_start = 1'b0; s_in_valid = 1'b0; s_in_data = 8'd0; s_out_ready = 1'b1;
        rst_n = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check("reset in_ready", in_ready, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_last", out_last, 0);
        check("reset done", done, 0);
        check("reset out_data", out_data, 0);
        check("reset small in_ready", s_in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle without start", {in_ready, out_valid, done}, 0);

        // ---------------- small instance: table-driven ----------------
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            for (int k = 0; k < 4; k++) begin
                s_in_valid = 1'b1;
                s_in_data  = 8'(10 * (k + 1) + 40 * ch);
                check($sformatf("small ch%0d load ready %0d", ch, k), s_in_ready, 1);
                @(negedge clk);
            end
            s_in_valid = 1'b0;
            check($sformatf("small ch%0d first out_valid", ch), s_out_valid, 1);
            for (int i = 0; i < 9; i++) begin
                if (i % 2 == 1) begin
                    s_out_ready = 1'b0;
                    @(negedge clk);
                    check($sformatf("small ch%0d stall %0d data", ch, i), s_out_data,
                          svec[i].data + 8'(40 * ch));
                end
                s_out_ready = 1'b1;
                check($sformatf("small ch%0d v%0d valid", ch, i), s_out_valid, 1);
                check($sformatf("small ch%0d v%0d data", ch, i), s_out_data,
                      svec[i].data + 8'(40 * ch));
                check($sformatf("small ch%0d v%0d last", ch, i), s_out_last, svec[i].last);
                @(negedge clk);
            end
        end
        check("small done pulse", s_done, 1);
        @(negedge clk);
        check("small done cleared", {s_done, s_in_ready, s_out_valid}, 0);

        // ---------------- frame A: stalls, stray inputs, reset in ch5 ----------
        pulse_start();
        load_channel(0, 1'b1, 1'b1);
        emit_channel(0, 1'b1, 1'b1, 1'b1);
        for (int ch = 1; ch < 5; ch++) begin
            load_channel(ch, 1'b0, 1'b0);
            emit_channel(ch, 1'b0, 1'b0, 1'b0);
        end
        load_channel(5, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        check("ch5 mid-emit out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid-emit reset outputs", {in_ready, out_valid, out_last, done, out_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post-reset waits in idle", {in_ready, out_valid, done}, 0);

        // ---------------- frame B: full 64-channel frame ----------------
        pulse_start();
        for (int ch = 0; ch < 64; ch++) begin
            load_channel(ch, 1'b0, 1'b0);
            emit_channel(ch, 1'b0, 1'b0, ch == 0);
        end
        check("frame done pulse", done, 1);
        check("done state no handshake", {in_ready, out_valid}, 0);
        @(negedge clk);
        check("done lasts one cycle", done, 0);
        repeat (3) @(negedge clk);
        check("back in idle", {in_ready, out_valid, done}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
